// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, general-call address, slave FSM states
// and the bus-event bundle produced by the condition detector.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;
  localparam logic [ADDR_W-1:0] GENCALL_ADDR = 7'h00;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } i2c_state_e;

  typedef struct packed {
    logic start;
    logic stop;
    logic scl_rise;
    logic scl_fall;
    logic sda;
  } bus_ev_t;

endpackage

// File: rtl/i2c_bus_cond.sv
// Registers SCL and the resolved bus SDA once and flags START/STOP and SCL
// edges as single-clk pulses, comparing live values against the registered copy.
module i2c_bus_cond
  import i2c_pkg::*;
(
  input  logic    clk,
  input  logic    RESET,
  input  logic    SCL,
  input  logic    SDA_OUT,
  input  logic    SDA_OE,
  input  logic    SDA_IN,
  output bus_ev_t ev
);

  logic sda_bus;
  logic scl_d, scl_q;
  logic sda_d, sda_q;

  assign sda_bus = SDA_OE ? SDA_OUT : SDA_IN;

  always_comb begin
    scl_d = SCL;
    sda_d = sda_bus;
  end

  // Idle-high reset values keep a release mid-transfer from looking like START/STOP
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  always_comb begin
    ev.start    = scl_q & SCL & sda_q & ~sda_bus;
    ev.stop     = scl_q & SCL & ~sda_q & sda_bus;
    ev.scl_rise = SCL & ~scl_q;
    ev.scl_fall = ~SCL & scl_q;
    ev.sda      = sda_bus;
  end

endmodule

// File: rtl/i2c_slave.sv
// Two-byte I2C slave on the system clock. Define I2C_SLAVE_GENCALL_EN to also
// accept general-call (7'h00) writes.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h2A,
  parameter int                DATA_W     = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              SCL,
  input  logic              SDA_OUT,
  input  logic              SDA_OE,
  output logic              SDA_IN,
  input  logic [DATA_W-1:0] RD_SRC,
  output logic [DATA_W-1:0] WR_DATA_OUT,
  output logic              WR_VALID,
  output logic              BUSY
);

  bus_ev_t ev;

  i2c_bus_cond u_cond (
    .clk     (clk),
    .RESET   (RESET),
    .SCL     (SCL),
    .SDA_OUT (SDA_OUT),
    .SDA_OE  (SDA_OE),
    .SDA_IN  (SDA_IN),
    .ev      (ev)
  );

  i2c_state_e        state_d, state_q;
  logic [3:0]        bit_cnt_d, bit_cnt_q;
  logic [1:0]        byte_cnt_d, byte_cnt_q;
  logic [BYTE_W-1:0] sr_d, sr_q, hi_d, hi_q;
  logic [DATA_W-1:0] tx_d, tx_q, wr_data_d, wr_data_q;
  logic              rw_d, rw_q, sda_in_d, sda_in_q;
  logic              wr_valid_d, wr_valid_q, busy_d, busy_q;
  logic [BYTE_W-1:0] rx_byte;
  logic              addr_hit;

  assign rx_byte = {sr_q[BYTE_W-2:0], ev.sda};

`ifdef I2C_SLAVE_GENCALL_EN
  assign addr_hit = (rx_byte[BYTE_W-1:1] == SLAVE_ADDR) ||
                    ((rx_byte[BYTE_W-1:1] == GENCALL_ADDR) && !rx_byte[0]);
`else
  assign addr_hit = (rx_byte[BYTE_W-1:1] == SLAVE_ADDR);
`endif

  // ACK states use bit_cnt as a phase: 0 = waiting to drive ACK, 1 = ACK on bus
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sr_d       = sr_q;
    hi_d       = hi_q;
    tx_d       = tx_q;
    wr_data_d  = wr_data_q;
    rw_d       = rw_q;
    sda_in_d   = sda_in_q;
    wr_valid_d = 1'b0;
    busy_d     = busy_q;
    if (ev.stop) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sda_in_d   = 1'b1;
    end else if (ev.start) begin
      state_d    = ADDR;
      busy_d     = 1'b1;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sda_in_d   = 1'b1;
    end else begin
      case (state_q)
        ADDR: if (ev.scl_rise) begin
          sr_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            rw_d      = rx_byte[0];
            state_d   = addr_hit ? ADDR_ACK : WAIT_STOP;
          end
        end
        ADDR_ACK: if (ev.scl_fall) begin
          if (bit_cnt_q == 4'd0) begin
            sda_in_d  = 1'b0;
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            if (rw_q) begin
              state_d  = RD_BYTE;
              tx_d     = RD_SRC;
              sda_in_d = RD_SRC[DATA_W-1];
            end else begin
              state_d  = WR_BYTE;
              sda_in_d = 1'b1;
            end
          end
        end
        WR_BYTE: if (ev.scl_rise) begin
          sr_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = (byte_cnt_q == 2'd2) ? WAIT_STOP : WR_ACK;
          end
        end
        WR_ACK: if (ev.scl_fall) begin
          if (bit_cnt_q == 4'd0) begin
            sda_in_d  = 1'b0;
            bit_cnt_d = 4'd1;
          end else begin
            sda_in_d  = 1'b1;
            bit_cnt_d = '0;
            state_d   = WR_BYTE;
            if (byte_cnt_q == 2'd0) begin
              hi_d       = sr_q;
              byte_cnt_d = 2'd1;
            end else begin
              wr_data_d  = DATA_W'({hi_q, sr_q});
              wr_valid_d = 1'b1;
              byte_cnt_d = 2'd2;
            end
          end
        end
        RD_BYTE: begin
          if (ev.scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (ev.scl_fall) begin
            tx_d = tx_q << 1;
            if (bit_cnt_q == 4'd8) begin
              state_d   = RD_ACK;
              sda_in_d  = 1'b1;
              bit_cnt_d = '0;
            end else begin
              sda_in_d = tx_q[DATA_W-2];
            end
          end
        end
        RD_ACK: begin
          if (ev.scl_rise) begin
            if (ev.sda || byte_cnt_q == 2'd1) state_d = WAIT_STOP;
            else bit_cnt_d = 4'd1;
          end else if (ev.scl_fall && bit_cnt_q == 4'd1) begin
            state_d    = RD_BYTE;
            sda_in_d   = tx_q[DATA_W-1];
            bit_cnt_d  = '0;
            byte_cnt_d = 2'd1;
          end
        end
        IDLE, WAIT_STOP: sda_in_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sr_q       <= '0;
      hi_q       <= '0;
      tx_q       <= '0;
      wr_data_q  <= '0;
      rw_q       <= 1'b0;
      sda_in_q   <= 1'b1;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sr_q       <= sr_d;
      hi_q       <= hi_d;
      tx_q       <= tx_d;
      wr_data_q  <= wr_data_d;
      rw_q       <= rw_d;
      sda_in_q   <= sda_in_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign SDA_IN      = sda_in_q;
  assign WR_DATA_OUT = wr_data_q;
  assign WR_VALID    = wr_valid_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged master on the system clock, expected write
// words and read bytes queued at stimulus time and popped when the DUT produces them.
module tb_i2c_slave;

  localparam int PH = 4;

  logic        clk = 1'b0;
  logic        RESET, SCL, SDA_OUT, SDA_OE;
  logic        SDA_IN, WR_VALID, BUSY;
  logic [15:0] RD_SRC, WR_DATA_OUT;

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0;
  int sda_lo_cnt = 0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  always #5 clk = ~clk;

  i2c_slave dut (
    .clk         (clk),
    .RESET       (RESET),
    .SCL         (SCL),
    .SDA_OUT     (SDA_OUT),
    .SDA_OE      (SDA_OE),
    .SDA_IN      (SDA_IN),
    .RD_SRC      (RD_SRC),
    .WR_DATA_OUT (WR_DATA_OUT),
    .WR_VALID    (WR_VALID),
    .BUSY        (BUSY)
  );

  // write scoreboard: every WR_VALID cycle must match the next queued word
  always @(negedge clk) begin
    if (RESET === 1'b1 && WR_VALID === 1'b1) begin
      logic [15:0] e;
      wv_cnt++;
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_valid_unexpected data=%h", WR_DATA_OUT);
      end else begin
        e = exp_wr.pop_front();
        if (WR_DATA_OUT !== e) begin
          errors++;
          $display("FAIL wr_data got=%h exp=%h", WR_DATA_OUT, e);
        end
      end
    end
    if (SDA_IN === 1'b0) sda_lo_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    SDA_OE = 1'b1; SDA_OUT = 1'b1; tick(PH);
    SCL = 1'b1; tick(PH);
    SDA_OUT = 1'b0; tick(PH);
    SCL = 1'b0; tick(PH);
  endtask

  task automatic bus_stop();
    SDA_OE = 1'b1; SDA_OUT = 1'b0; tick(PH);
    SCL = 1'b1; tick(PH);
    SDA_OUT = 1'b1; tick(PH);
  endtask

  task automatic put_bit(input logic b);
    SDA_OE = 1'b1; SDA_OUT = b; tick(PH);
    SCL = 1'b1; tick(PH);
    SCL = 1'b0; tick(PH);
  endtask

  task automatic get_bit(output logic b);
    SDA_OE = 1'b0; tick(PH);
    SCL = 1'b1; tick(PH / 2);
    b = SDA_IN;
    tick(PH / 2);
    SCL = 1'b0; tick(PH);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic test_reset();
    logic ack;
    RESET = 1'b0; SCL = 1'b1; SDA_OE = 1'b1; SDA_OUT = 1'b1; RD_SRC = 16'hA5C3;
    tick(3);
    checks++; if (SDA_IN !== 1'b1) begin errors++; $display("FAIL rst_sda got=%b exp=1", SDA_IN); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
    checks++; if (WR_VALID !== 1'b0) begin errors++; $display("FAIL rst_wr_valid got=%b exp=0", WR_VALID); end
    checks++; if (WR_DATA_OUT !== 16'h0) begin errors++; $display("FAIL rst_wr_data got=%h exp=0000", WR_DATA_OUT); end
    RESET = 1'b1; tick(2);
    SCL = 1'b0; tick(PH);
    sda_lo_cnt = 0;
    // matching address bits but no START: must be ignored
    put_byte(8'h54, ack);
    put_byte(8'h12, ack);
    checks++; if (sda_lo_cnt != 0) begin errors++; $display("FAIL no_start_sda_low got=%0d exp=0", sda_lo_cnt); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL no_start_busy got=%b exp=0", BUSY); end
  endtask

  task automatic test_write();
    logic ack;
    wv_cnt = 0;
    exp_wr.push_back(16'hBEEF);
    bus_start();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL wr_busy got=%b exp=1", BUSY); end
    put_byte(8'h54, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got=%b exp=0", ack); end
    put_byte(8'hBE, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_b0_ack got=%b exp=0", ack); end
    checks++; if (wv_cnt != 0) begin errors++; $display("FAIL wr_valid_early got=%0d exp=0", wv_cnt); end
    put_byte(8'hEF, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_b1_ack got=%b exp=0", ack); end
    checks++; if (wv_cnt != 1) begin errors++; $display("FAIL wr_valid_count got=%0d exp=1", wv_cnt); end
    checks++; if (WR_DATA_OUT !== 16'hBEEF) begin errors++; $display("FAIL wr_data_out got=%h exp=beef", WR_DATA_OUT); end
    bus_stop();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL wr_stop_busy got=%b exp=0", BUSY); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL wr_queue_left got=%0d exp=0", exp_wr.size()); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d, e;
    RD_SRC = 16'hA5C3;
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'hC3);
    bus_start();
    put_byte(8'h55, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
    get_byte(d, 1'b0);
    e = exp_rd.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL rd_byte0 got=%h exp=%h", d, e); end
    get_byte(d, 1'b1);
    e = exp_rd.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL rd_byte1 got=%h exp=%h", d, e); end
    tick(2);
    checks++; if (SDA_IN !== 1'b1) begin errors++; $display("FAIL rd_after_nack_sda got=%b exp=1", SDA_IN); end
    bus_stop();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rd_stop_busy got=%b exp=0", BUSY); end
  endtask

  task automatic test_mismatch();
    logic ack;
    wv_cnt = 0;
    sda_lo_cnt = 0;
    bus_start();
    put_byte(8'h56, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mis_addr_ack got=%b exp=1", ack); end
    put_byte(8'h12, ack);
    put_byte(8'h34, ack);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL mis_busy got=%b exp=1", BUSY); end
    bus_stop();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mis_stop_busy got=%b exp=0", BUSY); end
    checks++; if (sda_lo_cnt != 0) begin errors++; $display("FAIL mis_sda_low got=%0d exp=0", sda_lo_cnt); end
    checks++; if (wv_cnt != 0) begin errors++; $display("FAIL mis_wr_valid got=%0d exp=0", wv_cnt); end
  endtask

  task automatic test_rep_start();
    logic ack;
    logic [7:0] d, e;
    wv_cnt = 0;
    RD_SRC = 16'h3C96;
    bus_start();
    put_byte(8'h54, ack);
    put_byte(8'h12, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_b0_ack got=%b exp=0", ack); end
    bus_start();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rs_busy got=%b exp=1", BUSY); end
    put_byte(8'h55, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack got=%b exp=0", ack); end
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'h96);
    get_byte(d, 1'b0);
    e = exp_rd.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL rs_rd_byte0 got=%h exp=%h", d, e); end
    get_byte(d, 1'b1);
    e = exp_rd.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL rs_rd_byte1 got=%h exp=%h", d, e); end
    bus_stop();
    checks++; if (wv_cnt != 0) begin errors++; $display("FAIL rs_wr_valid got=%0d exp=0", wv_cnt); end
    checks++; if (WR_DATA_OUT !== 16'hBEEF) begin errors++; $display("FAIL rs_wr_data got=%h exp=beef", WR_DATA_OUT); end
  endtask

  task automatic test_reset_mid_read();
    logic ack, b;
    logic [7:0] d, e;
    RD_SRC = 16'hA5C3;
    bus_start();
    put_byte(8'h55, ack);
    get_bit(b);
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL mr_bit0 got=%b exp=1", b); end
    checks++; if (SDA_IN !== 1'b0) begin errors++; $display("FAIL mr_bit1_driven got=%b exp=0", SDA_IN); end
    RESET = 1'b0;
    #1;
    checks++; if (SDA_IN !== 1'b1) begin errors++; $display("FAIL mr_rst_sda got=%b exp=1", SDA_IN); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mr_rst_busy got=%b exp=0", BUSY); end
    tick(2);
    SDA_OE = 1'b1; SDA_OUT = 1'b1;
    RESET = 1'b1;
    tick(PH);
    RD_SRC = 16'h5AF0;
    exp_rd.push_back(8'h5A);
    exp_rd.push_back(8'hF0);
    bus_start();
    put_byte(8'h55, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mr_addr_ack got=%b exp=0", ack); end
    get_byte(d, 1'b0);
    e = exp_rd.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL mr_rd_byte0 got=%h exp=%h", d, e); end
    get_byte(d, 1'b1);
    e = exp_rd.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL mr_rd_byte1 got=%h exp=%h", d, e); end
    bus_stop();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mr_stop_busy got=%b exp=0", BUSY); end
  endtask

  task automatic test_gencall();
    logic ack;
    wv_cnt = 0;
`ifdef I2C_SLAVE_GENCALL_EN
    exp_wr.push_back(16'h0102);
`endif
    bus_start();
    put_byte(8'h00, ack);
`ifdef I2C_SLAVE_GENCALL_EN
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL gc_addr_ack got=%b exp=0", ack); end
`else
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL gc_addr_ack got=%b exp=1", ack); end
`endif
    put_byte(8'h01, ack);
    put_byte(8'h02, ack);
    bus_stop();
`ifdef I2C_SLAVE_GENCALL_EN
    checks++; if (wv_cnt != 1) begin errors++; $display("FAIL gc_wr_valid got=%0d exp=1", wv_cnt); end
    checks++; if (WR_DATA_OUT !== 16'h0102) begin errors++; $display("FAIL gc_wr_data got=%h exp=0102", WR_DATA_OUT); end
`else
    checks++; if (wv_cnt != 0) begin errors++; $display("FAIL gc_wr_valid got=%0d exp=0", wv_cnt); end
    checks++; if (WR_DATA_OUT !== 16'h0000) begin errors++; $display("FAIL gc_wr_data got=%h exp=0000", WR_DATA_OUT); end
`endif
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL gc_queue_left got=%0d exp=0", exp_wr.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_rep_start();
    test_reset_mid_read();
    test_gencall();
    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
